// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache line fill controller: FSM encoding,
// fill source select and default line geometry.
package cache_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } fill_src_t;

  localparam int DEF_BEATS = 4;
  localparam int DEF_IDX_W = 5;

  // Byte-offset bits inside one line: log2(beats) beat bits plus 3 for 64-bit beats.
  function automatic int line_ofs_bits(input int beats);
    return $clog2(beats) + 3;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: arbitrates I/D misses (D first), issues one
// line read to memory and streams the returned beats into the selected cache.
//
// state | meaning
// IDLE  | no line in flight; picks dmiss over imiss and latches its address
// REQ   | mem_req held with the aligned line address until mem_gnt
// WAIT  | collecting beats; idle timer aborts the line when it expires
// DONE  | last beat strobe is out; back to IDLE next cycle
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int BEATS   = DEF_BEATS,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     imiss,
  input  logic [31:0]              i_addr,
  input  logic                     dmiss,
  input  logic [31:0]              d_addr,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [63:0]              mem_rdata,
  output logic                     ifill,
  output logic                     dfill,
  output logic [IDX_W-1:0]         fill_idx,
  output logic [$clog2(BEATS)-1:0] fill_beat,
  output logic [63:0]              stream,
  output logic                     busy,
  output logic                     err
);

  localparam int BW = $clog2(BEATS);
  localparam int OFS = line_ofs_bits(BEATS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFS) - 32'd1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  fill_state_t     state;
  fill_src_t       src;
  fill_src_t       sel_src;
  logic [31:0]     sel_addr;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   idle_cnt;

  always_comb begin
    sel_addr = i_addr;
    sel_src  = SRC_I;
    if (dmiss) begin
      sel_addr = d_addr;
      sel_src  = SRC_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      src       <= SRC_I;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ifill     <= 1'b0;
      dfill     <= 1'b0;
      fill_idx  <= '0;
      fill_beat <= '0;
      stream    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ifill <= 1'b0;
      dfill <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dmiss || imiss) begin
            state    <= ST_REQ;
            src      <= sel_src;
            mem_req  <= 1'b1;
            mem_addr <= sel_addr & ALIGN_MASK;
            fill_idx <= IDX_W'(sel_addr >> OFS);
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state    <= ST_WAIT;
            mem_req  <= 1'b0;
            idle_cnt <= IDLE_LOAD;
          end
        end
        ST_WAIT: begin
          // A beat wins over an expiring timer in the same cycle.
          if (mem_rvalid) begin
            ifill     <= (src == SRC_I);
            dfill     <= (src == SRC_D);
            stream    <= mem_rdata;
            fill_beat <= beat_cnt;
            beat_cnt  <= beat_cnt + BW'(1);
            idle_cnt  <= IDLE_LOAD;
            if (beat_cnt == LAST_BEAT) begin
              state <= ST_DONE;
            end
          end else if (idle_cnt == '0) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt - TW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: directed miss/beat scenarios push
// expected requests and strobes; a negedge monitor pops and compares.
module tb_cache_fill_ctrl;

  localparam int BEATS   = 4;
  localparam int IDX_W   = 5;
  localparam int TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        imiss;
  logic [31:0] i_addr;
  logic        dmiss;
  logic [31:0] d_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ifill;
  logic        dfill;
  logic [IDX_W-1:0] fill_idx;
  logic [1:0]  fill_beat;
  logic [63:0] stream;
  logic        busy;
  logic        err;

  cache_fill_ctrl #(.BEATS(BEATS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imiss(imiss), .i_addr(i_addr), .dmiss(dmiss), .d_addr(d_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ifill(ifill), .dfill(dfill), .fill_idx(fill_idx), .fill_beat(fill_beat),
    .stream(stream), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = ifill strobe, 1 = dfill strobe, 2 = err pulse
  typedef struct {
    int          kind;
    int          idx;
    int          beat;
    logic [63:0] data;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] req_q[$];
  int checks = 0;
  int errors = 0;
  ev_t         mon_e;
  logic [31:0] mon_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int kind, input int idx, input logic [63:0] base, input int n);
    ev_t e;
    for (int b = 0; b < n; b++) begin
      e.kind = kind; e.idx = idx; e.beat = b; e.data = base + 64'(b);
      ev_q.push_back(e);
    end
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = 2; e.idx = 0; e.beat = 0; e.data = '0;
    ev_q.push_back(e);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!mem_req && n < 30) begin
      tick(1);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL %s: mem_req not seen within 30 cycles, required 1", name);
    end
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    tick(1);
    mem_gnt = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 64'(b);
      tick(1);
      mem_rvalid = 1'b0;
      mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
      if (gap > 0) tick(gap);
    end
  endtask

  always @(negedge clk) begin
    if (ifill || dfill || err) begin
      if (ev_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got ifill=%0b dfill=%0b err=%0b, required none (t=%0t)",
                 ifill, dfill, err, $time);
      end else begin
        mon_e = ev_q.pop_front();
        chk("fill_exclusive", 64'(ifill & dfill), 64'd0);
        chk("event_kind", err ? 64'd2 : (dfill ? 64'd1 : 64'd0), 64'(mon_e.kind));
        if (mon_e.kind != 2) begin
          chk("fill_idx", 64'(fill_idx), 64'(mon_e.idx));
          chk("fill_beat", 64'(fill_beat), 64'(mon_e.beat));
          chk("stream", stream, mon_e.data);
        end
      end
    end
    if (mem_req && mem_gnt) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request: got mem_addr=%0h, required none", mem_addr);
      end else begin
        mon_a = req_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(mon_a));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imiss = 1'b0; dmiss = 1'b0; i_addr = '0; d_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(3);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ctrl", 64'({mem_req, ifill, dfill, err}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_fill", 64'({fill_idx, fill_beat}), 64'd0);
    chk("reset_stream", stream, 64'd0);
    reset = 1'b0;
    tick(2);
    chk("idle_busy", 64'(busy), 64'd0);

    // I-miss, grant after 2 cycles, 4 back-to-back beats
    req_q.push_back(32'h0000_1220);
    push_beats(0, 'h11, 64'hA000_0000_0000_00D0, 4);
    i_addr = 32'h0000_1234; imiss = 1'b1;
    wait_req("req_imiss");
    chk("busy_in_req", 64'(busy), 64'd1);
    tick(2);
    imiss = 1'b0;
    grant();
    send_beats(64'hA000_0000_0000_00D0, 4, 0);
    tick(2);
    chk("busy_after_line", 64'(busy), 64'd0);

    // simultaneous misses: D line first, then I line
    req_q.push_back(32'h0000_0040);
    req_q.push_back(32'h0000_0080);
    push_beats(1, 2, 64'hB000_0000_0000_0000, 4);
    push_beats(0, 4, 64'hC000_0000_0000_0000, 4);
    d_addr = 32'h0000_0040; i_addr = 32'h0000_0080;
    dmiss = 1'b1; imiss = 1'b1;
    wait_req("req_dfirst");
    dmiss = 1'b0;
    grant();
    send_beats(64'hB000_0000_0000_0000, 4, 0);
    wait_req("req_ithen");
    imiss = 1'b0;
    grant();
    send_beats(64'hC000_0000_0000_0000, 4, 0);
    tick(2);

    // beats with 3-cycle gaps, unaligned miss address
    req_q.push_back(32'h0000_3FC0);
    push_beats(1, 'h1E, 64'hE000_0000_0000_0000, 4);
    d_addr = 32'h0000_3FD8; dmiss = 1'b1;
    wait_req("req_gaps");
    dmiss = 1'b0;
    grant();
    send_beats(64'hE000_0000_0000_0000, 4, 3);
    tick(2);
    chk("busy_after_gaps", 64'(busy), 64'd0);

    // timeout after 2 beats; imiss stays high so a new request follows
    req_q.push_back(32'h0000_0200);
    push_beats(0, 'h10, 64'hF000_0000_0000_0000, 2);
    push_err();
    req_q.push_back(32'h0000_0200);
    i_addr = 32'h0000_0200; imiss = 1'b1;
    wait_req("req_timeout");
    grant();
    send_beats(64'hF000_0000_0000_0000, 2, 0);
    tick(7);
    chk("err_not_early", 64'(err), 64'd0);
    chk("busy_before_abort", 64'(busy), 64'd1);
    tick(1);
    chk("err_pulse", 64'(err), 64'd1);
    chk("busy_after_abort", 64'(busy), 64'd0);
    tick(1);
    chk("err_one_cycle", 64'(err), 64'd0);
    wait_req("req_retry");

    // reset after beat 1 of 4; later beats must be ignored
    push_beats(0, 'h10, 64'h1100_0000_0000_0000, 2);
    imiss = 1'b0;
    grant();
    send_beats(64'h1100_0000_0000_0000, 2, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midline_rst_busy", 64'(busy), 64'd0);
    chk("midline_rst_ctrl", 64'({mem_req, ifill, dfill, err}), 64'd0);
    chk("midline_rst_fill", 64'({fill_idx, fill_beat}), 64'd0);
    chk("midline_rst_stream", stream, 64'd0);
    chk("midline_rst_addr", 64'(mem_addr), 64'd0);
    send_beats(64'h1100_0000_0000_0002, 2, 0);
    tick(2);
    chk("busy_after_rst", 64'(busy), 64'd0);

    // grant withheld 10 cycles: request held stable, stray beats ignored
    req_q.push_back(32'hDEAD_BEE0);
    push_beats(1, 'h17, 64'h2200_0000_0000_0000, 4);
    d_addr = 32'hDEAD_BEEF; dmiss = 1'b1;
    wait_req("req_hold");
    d_addr = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      chk("req_held", 64'(mem_req), 64'd1);
      chk("addr_held", 64'(mem_addr), 64'hDEAD_BEE0);
      mem_rvalid = (i == 3 || i == 7);
      mem_rdata  = 64'h5555_0000_0000_0000 + 64'(i);
      tick(1);
    end
    mem_rvalid = 1'b0;
    dmiss = 1'b0;
    grant();
    send_beats(64'h2200_0000_0000_0000, 4, 0);
    tick(3);

    chk("events_drained", 64'(ev_q.size()), 64'd0);
    chk("requests_drained", 64'(req_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter BEATS, default 4: 64-bit beats per cache line; power of two, 2..8.
REQ-002 Parameter IDX_W, default 5: cache line index width.
REQ-003 Parameter TIMEOUT, default 255: maximum idle cycles between beats in WAIT before abort.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port reset  in  1  reset, synchronous, active-high.
REQ-006 Port imiss  in  1  instruction-cache miss, level, held until serviced.
REQ-007 Port i_addr  in  32  instruction miss address.
REQ-008 Port dmiss  in  1  data-cache miss, level, held until serviced.
REQ-009 Port d_addr  in  32  data miss address.
REQ-010 Port mem_req  out  1  line-read request to memory.
REQ-011 Port mem_addr  out  32  line-aligned request address.
REQ-012 Port mem_gnt  in  1  memory accepts request.
REQ-013 Port mem_rvalid  in  1  read beat valid.
REQ-014 Port mem_rdata  in  64  read beat data.
REQ-015 Port ifill / dfill  out  1 each  write strobe into I-cache / D-cache.
REQ-016 Port fill_idx  out  IDX_W  cache line index being filled.
REQ-017 Port fill_beat  out  log2(BEATS)  beat position within line.
REQ-018 Port stream  out  64  fill data.
REQ-019 Port busy  out  1  high in every state except IDLE.
REQ-020 Port err  out  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states: IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: if dmiss, latch d_addr and select D; else if imiss, latch i_addr and select I; go to REQ next cycle.
REQ-023 Simultaneous imiss and dmiss: D served first; I served on the next IDLE pass if still asserted.
REQ-024 REQ: mem_req=1, mem_addr=latched address with low log2(BEATS)+3 bits zero; hold until the cycle mem_gnt=1, then enter WAIT.
REQ-025 mem_addr stays stable while mem_req=1.
REQ-026 WAIT: each mem_rvalid beat is registered; one cycle later the selected fill strobe is 1, stream=beat data, fill_beat=beat count.
REQ-027 Beats are in ascending order from 0; the beat counter wraps to 0 after BEATS-1.
REQ-028 fill_idx = latched address bits [IDX_W+log2(BEATS)+2 : log2(BEATS)+3], constant for the whole line.
REQ-029 The last beat (count BEATS-1) moves to DONE; DONE lasts one cycle, then IDLE; the strobe for the last beat fires in the DONE cycle.
REQ-030 In WAIT, an idle counter resets on each beat; reaching TIMEOUT returns to IDLE with err=1 for one cycle and no further strobes.
REQ-031 mem_rvalid in IDLE, REQ or DONE is ignored.
REQ-032 ifill and dfill are never both 1.
REQ-033 Back-to-back lines: the minimum gap is IDLE to REQ = 1 cycle after DONE.

Reset
REQ-034 reset forces IDLE in the next cycle, including mid-line; partial lines are abandoned.
REQ-035 Reset values: mem_req, ifill, dfill, busy, err=0; mem_addr, fill_idx, fill_beat, stream=0; counters=0.
REQ-036 Beats arriving after reset are ignored under REQ-031.

Structure
REQ-037 FSM state encoding, the BEATS/IDX_W defaults and the source-select enum (SRC_I, SRC_D) live in the shared pipeline package.
REQ-038 The block is single-level; no sub-module is required. The beat/timeout counter may be a local always block.

Verification
REQ-039 imiss=1, i_addr=0x0000_1234, gnt after 2 cycles, 4 back-to-back beats D0..D3 -> mem_addr=0x0000_1220; ifill pulses 4 cycles; fill_idx=0x11; fill_beat 0..3; stream D0..D3; dfill=0.
REQ-040 imiss and dmiss rise together, d_addr=0x40, i_addr=0x80 -> D line filled first (mem_addr=0x40, dfill); then mem_addr=0x80 with ifill.
REQ-041 Beats separated by 3-cycle gaps -> strobes follow each beat with 1-cycle latency; line completes; err=0.
REQ-042 TIMEOUT=8, only 2 beats delivered -> err pulses once 8 cycles after beat 1; return to IDLE; imiss still high -> new REQ issued.
REQ-043 reset asserted after beat 1 of 4 -> next cycle busy=0 and all outputs 0; the remaining beats cause no strobes.
REQ-044 mem_gnt held low 10 cycles -> mem_req and mem_addr stay constant for all 10 cycles; no strobes.
